// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared definitions for the 2048x144 single-port SRAM controller:
// FSM state encoding, array depth and round-robin pointer encoding.
package ct_spsram_ctrl_pkg;

    localparam int ENTRIES = 2048;

    // INIT sweeps the array to zero, RUN serves the two requesters.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Side that received the most recent grant.
    typedef enum logic {
        LAST_RD = 1'b0,
        LAST_WR = 1'b1
    } last_gnt_e;

endpackage

// File: rtl/ct_spsram_ctrl_arb.sv
// Two-way round-robin arbiter between the write and read requesters.
// A lone requester is granted in the same cycle; on a tie the side not
// granted last wins. The pointer only moves when a grant is issued.
module ct_spsram_ctrl_arb
    import ct_spsram_ctrl_pkg::*;
(
    input  logic forever_cpuclk,
    input  logic cpurst_b,
    input  logic arb_en,
    input  logic wr_req,
    input  logic rd_req,
    output logic wr_gnt,
    output logic rd_gnt
);

    last_gnt_e last_q;

    // Grant decision from the requests and the last-grant pointer.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (arb_en) begin
            if (wr_req && rd_req) begin
                if (last_q == LAST_RD) wr_gnt = 1'b1;
                else                   rd_gnt = 1'b1;
            end else begin
                wr_gnt = wr_req;
                rd_gnt = rd_req;
            end
        end
    end

    // Last-grant pointer; starts as "read last" so write wins the first tie.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!cpurst_b)   last_q <= LAST_RD;
        else if (wr_gnt) last_q <= LAST_WR;
        else if (rd_gnt) last_q <= LAST_RD;
    end

endmodule

// File: rtl/ct_spsram_2048x144_ctrl.sv
// Controller for a 2048x144 single-port SRAM with a write and a read
// requester. Optional macro CT_SPSRAM_CTRL_INIT_EN adds a zero-fill sweep
// after reset and on flush_req; without it the block starts in RUN.
module ct_spsram_2048x144_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 144
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bwen,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  flush_req,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    logic                  in_init;
    logic                  arb_en;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;

`ifdef CT_SPSRAM_CTRL_INIT_EN
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Sweep sequencing: count through the array, flush restarts at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and sweep counter registers.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_init   = (state_q == ST_INIT);
    assign init_done = (state_q == ST_RUN);
`else
    logic unused_flush;

    assign unused_flush = flush_req;
    assign in_init      = 1'b0;
    assign init_done    = 1'b1;
`endif

    // Requests are only arbitrated out of reset and outside the sweep.
    assign arb_en = cpurst_b & ~in_init;

    ct_spsram_ctrl_arb u_arb (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .arb_en         (arb_en),
        .wr_req         (wr_req),
        .rd_req         (rd_req),
        .wr_gnt         (wr_gnt),
        .rd_gnt         (rd_gnt)
    );

    // SRAM port mux: sweep write, granted write, granted read or idle.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_q;
        sram_d    = d_q;
        if (!cpurst_b) begin
            sram_cen = 1'b1;
        end
`ifdef CT_SPSRAM_CTRL_INIT_EN
        else if (in_init) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt_q;
            sram_d    = '0;
        end
`endif
        else if (wr_gnt) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = wr_bwen;
            sram_a    = wr_addr;
            sram_d    = wr_data;
        end else if (rd_gnt) begin
            sram_cen  = 1'b0;
            sram_a    = rd_addr;
        end
    end

    // Address hold register and read-valid pipeline stage.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            a_q    <= '0;
            rd_vld <= 1'b0;
        end else begin
            a_q    <= sram_a;
            rd_vld <= rd_gnt;
        end
    end

    // Write-data hold register.
    always_ff @(posedge forever_cpuclk) begin
        // NOTE: wide datapath holding register needs no reset; sram_cen qualifies its use.
        d_q <= sram_d;
    end

    assign rd_data = sram_q;

endmodule

// File: tb/tb_ct_spsram_2048x144_ctrl.sv
// Directed self-checking bench for ct_spsram_2048x144_ctrl with a
// behavioural SRAM model. Covers both CT_SPSRAM_CTRL_INIT_EN builds.
module tb_ct_spsram_2048x144_ctrl;
    import ct_spsram_ctrl_pkg::*;

    localparam int AW = 11;
    localparam int DW = 144;

    logic          forever_cpuclk = 1'b0;
    logic          cpurst_b;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_bwen;
    logic          wr_gnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          flush_req;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    logic [DW-1:0] mem [0:ENTRIES-1];

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [DW-1:0] PAT_A5  = {18{8'hA5}};
    localparam logic [DW-1:0] PAT_W10 = {9{16'h1E10}};
    localparam logic [DW-1:0] MASK_D  = {72'h0, 72'h5A0123456789ABCDEF};
    localparam logic [DW-1:0] MASK_Q  = {72'hFFFFFFFFFFFFFFFFFF, 72'h5A0123456789ABCDEF};

    always #5 forever_cpuclk = ~forever_cpuclk;

    ct_spsram_2048x144_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_bwen        (wr_bwen),
        .wr_gnt         (wr_gnt),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_vld         (rd_vld),
        .rd_data        (rd_data),
        .flush_req      (flush_req),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    // Behavioural single-port SRAM: bit-masked write, registered read.
    always @(posedge forever_cpuclk) begin
        if (sram_cen === 1'b0) begin
            if (sram_gwen === 1'b0)
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= mem[sram_a];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge forever_cpuclk);
        #1;
    endtask

    // Checks one full zero sweep starting at the next falling edge, then RUN.
    task automatic run_sweep(input string tag);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < ENTRIES; i++) begin
            @(negedge forever_cpuclk);
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== AW'(i) ||
                sram_wen !== '0 || sram_d !== '0 || wr_gnt !== 1'b0 ||
                rd_gnt !== 1'b0 || init_done !== 1'b0)
                ok = 1'b0;
        end
        check({tag, "_sweep"}, DW'(ok), DW'(1'b1));
        @(negedge forever_cpuclk);
        check({tag, "_init_done"}, DW'(init_done), DW'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cpurst_b  = 1'b0;
        wr_req    = 1'b1;
        wr_addr   = '0;
        wr_data   = '0;
        wr_bwen   = '0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        flush_req = 1'b0;

        // Reset: no grant, SRAM idle, rd_vld low even with a request held.
        repeat (3) @(negedge forever_cpuclk);
        check("rst_wr_gnt", DW'(wr_gnt), DW'(1'b0));
        check("rst_cen", DW'(sram_cen), DW'(1'b1));
        check("rst_rd_vld", DW'(rd_vld), DW'(1'b0));
`ifdef CT_SPSRAM_CTRL_INIT_EN
        check("rst_init_done", DW'(init_done), DW'(1'b0));

        // Partial sweep interrupted by reset at address 1000.
        next_cycle();
        cpurst_b = 1'b1;
        repeat (1000) @(negedge forever_cpuclk);
        @(negedge forever_cpuclk);
        check("mid_sweep_a", DW'(sram_a), DW'(11'd1000));
        check("mid_sweep_no_gnt", DW'(wr_gnt), DW'(1'b0));
        cpurst_b = 1'b0;
        #1;
        check("mid_rst_cen", DW'(sram_cen), DW'(1'b1));
        wr_req = 1'b0;
        next_cycle();
        cpurst_b = 1'b1;
        run_sweep("post_reset");
`else
        check("rst_init_done", DW'(init_done), DW'(1'b1));
        wr_req = 1'b0;
        next_cycle();
        cpurst_b = 1'b1;
        @(negedge forever_cpuclk);
        check("post_rst_init_done", DW'(init_done), DW'(1'b1));
        check("post_rst_idle_cen", DW'(sram_cen), DW'(1'b1));
`endif

        // Full write to address 5, then read it back the next cycle.
        next_cycle();
        wr_req = 1'b1; wr_addr = 11'd5; wr_data = PAT_A5; wr_bwen = '0;
        @(negedge forever_cpuclk);
        check("w5_gnt", DW'(wr_gnt), DW'(1'b1));
        check("w5_cen_gwen", DW'({sram_cen, sram_gwen}), DW'(2'b00));
        check("w5_a", DW'(sram_a), DW'(11'd5));
        check("w5_d", sram_d, PAT_A5);
        check("w5_wen", sram_wen, '0);
        next_cycle();
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 11'd5;
        @(negedge forever_cpuclk);
        check("r5_gnt", DW'({wr_gnt, rd_gnt}), DW'(2'b01));
        check("r5_ctl", DW'({sram_cen, sram_gwen}), DW'(2'b01));
        check("r5_wen", sram_wen, '1);
        check("r5_vld_early", DW'(rd_vld), DW'(1'b0));
        next_cycle();
        rd_req = 1'b0;
        @(negedge forever_cpuclk);
        check("r5_vld", DW'(rd_vld), DW'(1'b1));
        check("r5_data", rd_data, PAT_A5);
        check("idle_cen", DW'(sram_cen), DW'(1'b1));
        check("idle_a_hold", DW'(sram_a), DW'(11'd5));

        // Both requesters held four cycles: W, R, W, R.
        next_cycle();
        wr_req = 1'b1; wr_addr = 11'd10; wr_data = PAT_W10;
        rd_req = 1'b1; rd_addr = 11'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge forever_cpuclk);
            check($sformatf("rr_%0d", i), DW'({wr_gnt, rd_gnt}),
                  (i % 2 == 0) ? DW'(2'b10) : DW'(2'b01));
            next_cycle();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge forever_cpuclk);
        check("rr_vld", DW'(rd_vld), DW'(1'b1));
        check("rr_data", rd_data, PAT_A5);

        // Bit-masked write over an all-ones word, read the next cycle.
        next_cycle();
        wr_req = 1'b1; wr_addr = 11'd20; wr_data = '1; wr_bwen = '0;
        next_cycle();
        wr_data = MASK_D; wr_bwen = {{72{1'b1}}, {72{1'b0}}};
        @(negedge forever_cpuclk);
        check("mask_wen", sram_wen, {{72{1'b1}}, {72{1'b0}}});
        next_cycle();
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 11'd20;
        next_cycle();
        rd_req = 1'b0;
        @(negedge forever_cpuclk);
        check("mask_data", rd_data, MASK_Q);

        // Flush with a same-cycle read of address 5.
        next_cycle();
        flush_req = 1'b1; rd_req = 1'b1; rd_addr = 11'd5;
        @(negedge forever_cpuclk);
        check("flush_rd_gnt", DW'(rd_gnt), DW'(1'b1));
        next_cycle();
        flush_req = 1'b0; rd_req = 1'b0;
        check("flush_rd_vld", DW'(rd_vld), DW'(1'b1));
        check("flush_rd_data", rd_data, PAT_A5);
`ifdef CT_SPSRAM_CTRL_INIT_EN
        run_sweep("flush");
`else
        @(negedge forever_cpuclk);
        check("flush_ignored", DW'({init_done, sram_cen}), DW'(2'b11));
`endif
        next_cycle();
        rd_req = 1'b1; rd_addr = 11'd5;
        next_cycle();
        rd_req = 1'b0;
        @(negedge forever_cpuclk);
        check("post_flush_vld", DW'(rd_vld), DW'(1'b1));
`ifdef CT_SPSRAM_CTRL_INIT_EN
        check("post_flush_data", rd_data, '0);
`else
        check("post_flush_data", rd_data, PAT_A5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
